// File: rtl/hwpe_ctrl_ucode_flags_buffer.sv
// Flags buffer between the microcode loop engine and the streamer: a small FIFO of per-iteration
// flags that throttles the uloop via enable. Define HWPE_CTRL_UCODE_BUF_BYPASS_EN for an empty-FIFO bypass path.
module hwpe_ctrl_ucode_flags_buffer #(
    parameter int DEPTH     = 4,
    parameter int NB_REG    = 4,
    parameter int NB_LOOPS  = 6,
    parameter int CNT_WIDTH = 12,
    parameter int LATENCY   = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          in_valid_i,
    input  logic                          in_done_i,
    input  logic                          in_accum_i,
    input  logic [NB_REG*32-1:0]          in_offs_i,
    input  logic [NB_LOOPS*CNT_WIDTH-1:0] in_idx_i,
    output logic                          uloop_enable_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [NB_REG*32-1:0]          out_offs_o,
    output logic [NB_LOOPS*CNT_WIDTH-1:0] out_idx_o,
    output logic                          out_accum_o,
    output logic                          out_last_o,
    output logic                          done_o,
    output logic [$clog2(DEPTH):0]        count_o,
    output logic                          overflow_o
);

    localparam int OFFS_W = NB_REG * 32;
    localparam int IDX_W  = NB_LOOPS * CNT_WIDTH;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic [OFFS_W-1:0] r_offs [DEPTH];
    logic [IDX_W-1:0]  r_idx  [DEPTH];
    logic [DEPTH-1:0]  r_accum;
    logic [DEPTH-1:0]  r_last;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_done;

    logic [OFFS_W-1:0] r_holdOffs;
    logic [IDX_W-1:0]  r_holdIdx;
    logic              r_holdAccum;
    logic              r_holdLast;

    logic              w_empty;
    logic              w_full;
    logic              w_bypass;
    logic              w_pop;
    logic              w_push;
    logic              w_pushAccept;
    logic              w_pushDrop;
    logic              w_doneAlone;
    logic              w_markTail;
    logic              w_doneDirect;
    logic              w_doneNext;
    logic [PTR_W-1:0]  w_tailPrev;
    logic [CNT_W-1:0]  w_free;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));

`ifdef HWPE_CTRL_UCODE_BUF_BYPASS_EN
    assign w_bypass = w_empty & in_valid_i & out_ready_i;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_pop        = ~w_empty & out_ready_i;
    assign w_push       = in_valid_i & ~w_bypass;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_pushAccept = w_push & (~w_full | w_pop);
    assign w_pushDrop   = w_push & w_full & ~w_pop;

    // A lone done either tags the newest stored entry or, when nothing survives this cycle,
    // finishes the job directly.
    assign w_doneAlone  = in_done_i & ~in_valid_i;
    assign w_markTail   = w_doneAlone & ~w_empty & ~((r_count == CNT_W'(1)) & w_pop);
    assign w_doneDirect = w_doneAlone & ~w_markTail;
    assign w_doneNext   = (w_pop & r_last[r_head]) | w_doneDirect | (w_bypass & in_done_i);

    assign w_tailPrev = r_tail - PTR_W'(1);
    assign w_free     = CNT_W'(DEPTH) - r_count;

    assign uloop_enable_o = rst_ni & ~clear_i & (w_free > CNT_W'(LATENCY));
    assign count_o        = r_count;
    assign overflow_o     = r_overflow;
    assign done_o         = r_done;

    // Output view: bypassed input, else the head entry, else the last value that left.
    always_comb begin
        out_valid_o = ~w_empty | w_bypass;
        out_offs_o  = r_holdOffs;
        out_idx_o   = r_holdIdx;
        out_accum_o = r_holdAccum;
        out_last_o  = r_holdLast;
        if (w_bypass) begin
            out_offs_o  = in_offs_i;
            out_idx_o   = in_idx_i;
            out_accum_o = in_accum_i;
            out_last_o  = in_done_i;
        end else if (!w_empty) begin
            out_offs_o  = r_offs[r_head];
            out_idx_o   = r_idx[r_head];
            out_accum_o = r_accum[r_head];
            out_last_o  = r_last[r_head];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_offs[i] <= '0;
                r_idx[i]  <= '0;
            end
            r_accum <= '0;
            r_last  <= '0;
        end else begin
            if (w_pushAccept) begin
                r_offs[r_tail]  <= in_offs_i;
                r_idx[r_tail]   <= in_idx_i;
                r_accum[r_tail] <= in_accum_i;
                r_last[r_tail]  <= in_done_i;
            end
            if (w_markTail) begin
                r_last[w_tailPrev] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pushAccept) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_pushAccept, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_holdOffs  <= '0;
            r_holdIdx   <= '0;
            r_holdAccum <= 1'b0;
            r_holdLast  <= 1'b0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_pop) begin
                r_holdOffs  <= r_offs[r_head];
                r_holdIdx   <= r_idx[r_head];
                r_holdAccum <= r_accum[r_head];
                r_holdLast  <= r_last[r_head];
            end else if (w_bypass) begin
                r_holdOffs  <= in_offs_i;
                r_holdIdx   <= in_idx_i;
                r_holdAccum <= in_accum_i;
                r_holdLast  <= in_done_i;
            end
            if (w_pushDrop) begin
                r_overflow <= 1'b1;
            end
            r_done <= w_doneNext;
        end
    end

endmodule

// File: tb/tb_hwpe_ctrl_ucode_flags_buffer.sv
// Self-checking bench for hwpe_ctrl_ucode_flags_buffer (default build): directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_hwpe_ctrl_ucode_flags_buffer;

    localparam int DEPTH     = 4;
    localparam int NB_REG    = 4;
    localparam int NB_LOOPS  = 6;
    localparam int CNT_WIDTH = 12;
    localparam int LATENCY   = 1;
    localparam int OFFS_W    = NB_REG * 32;
    localparam int IDX_W     = NB_LOOPS * CNT_WIDTH;
    localparam int CNT_W     = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [OFFS_W-1:0] offs;
        logic [IDX_W-1:0]  idx;
        logic              accum;
        logic              last;
    } entry_t;

    logic              clk_i;
    logic              rst_ni;
    logic              clear_i;
    logic              in_valid_i;
    logic              in_done_i;
    logic              in_accum_i;
    logic [OFFS_W-1:0] in_offs_i;
    logic [IDX_W-1:0]  in_idx_i;
    logic              uloop_enable_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [OFFS_W-1:0] out_offs_o;
    logic [IDX_W-1:0]  out_idx_o;
    logic              out_accum_o;
    logic              out_last_o;
    logic              done_o;
    logic [CNT_W-1:0]  count_o;
    logic              overflow_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO contents as a queue plus the observable sticky/pulse state.
    entry_t mq[$];
    logic   mOverflow = 1'b0;
    logic   mDone     = 1'b0;
    entry_t mHold     = '0;

    hwpe_ctrl_ucode_flags_buffer #(
        .DEPTH(DEPTH), .NB_REG(NB_REG), .NB_LOOPS(NB_LOOPS), .CNT_WIDTH(CNT_WIDTH), .LATENCY(LATENCY)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .in_valid_i(in_valid_i), .in_done_i(in_done_i), .in_accum_i(in_accum_i),
        .in_offs_i(in_offs_i), .in_idx_i(in_idx_i),
        .uloop_enable_o(uloop_enable_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_offs_o(out_offs_o), .out_idx_o(out_idx_o), .out_accum_o(out_accum_o),
        .out_last_o(out_last_o), .done_o(done_o), .count_o(count_o), .overflow_o(overflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic drive(input logic v, input logic d, input logic a, input logic [31:0] offs0,
                         input logic rdy, input logic clr);
        in_valid_i  = v;
        in_done_i   = d;
        in_accum_i  = a;
        out_ready_i = rdy;
        clear_i     = clr;
        for (int k = 0; k < NB_REG; k++) in_offs_i[k*32 +: 32] = $urandom();
        in_offs_i[31:0] = offs0;
        for (int k = 0; k < NB_LOOPS; k++) in_idx_i[k*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'($urandom());
        #1;
    endtask

    // Advance the model by the cycle's inputs, then let the DUT take the same clock edge.
    task automatic step();
        int     sz;
        bit     pop;
        entry_t e;
        entry_t t;
        sz = mq.size();
        if (!rst_ni || clear_i) begin
            mq.delete();
            mOverflow = 1'b0;
            mDone     = 1'b0;
            mHold     = '0;
        end else begin
            mDone = 1'b0;
            pop   = (sz > 0) && out_ready_i;
            if (pop) begin
                if (mq[0].last) mDone = 1'b1;
                mHold = mq[0];
                void'(mq.pop_front());
            end
            if (in_valid_i) begin
                e.offs  = in_offs_i;
                e.idx   = in_idx_i;
                e.accum = in_accum_i;
                e.last  = in_done_i;
                if (sz < DEPTH || pop) mq.push_back(e);
                else mOverflow = 1'b1;
            end else if (in_done_i) begin
                if (sz > 0 && !(sz == 1 && pop)) begin
                    t = mq[mq.size()-1];
                    t.last = 1'b1;
                    mq[mq.size()-1] = t;
                end else begin
                    mDone = 1'b1;
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 1'b1, 32'hdead, 1'b1, 1'b0);
            checks++; if (uloop_enable_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_enable got=%b exp=0", uloop_enable_o); end
            step();
        end
        rst_ni = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (count_o !== '0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count_o); end
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", out_valid_o); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done_o); end
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow_o); end
        checks++; if (out_offs_o !== '0) begin failures++; $display("[TB] FAIL reset_offs got=%h exp=0", out_offs_o); end
        checks++; if (out_idx_o !== '0) begin failures++; $display("[TB] FAIL reset_idx got=%h exp=0", out_idx_o); end
        checks++; if ({out_accum_o, out_last_o} !== 2'b00) begin failures++; $display("[TB] FAIL reset_flags got=%b%b exp=00", out_accum_o, out_last_o); end
        checks++; if (uloop_enable_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_enable_after got=%b exp=1", uloop_enable_o); end
    endtask

    task automatic test_stream();
        for (int k = 0; k <= 8; k++) begin
            drive(k < 8, 1'b0, 1'b0, 32'(16 * k), 1'b1, 1'b0);
            if (k > 0) begin
                checks++; if (out_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL stream_valid k=%0d got=%b exp=1", k, out_valid_o); end
                checks++; if (out_offs_o[31:0] !== 32'(16 * (k - 1))) begin failures++; $display("[TB] FAIL stream_offs k=%0d got=%h exp=%h", k, out_offs_o[31:0], 16 * (k - 1)); end
                checks++; if (count_o > CNT_W'(1)) begin failures++; $display("[TB] FAIL stream_count k=%0d got=%0d exp<=1", k, count_o); end
                checks++; if (overflow_o !== 1'b0) begin failures++; $display("[TB] FAIL stream_overflow k=%0d got=%b exp=0", k, overflow_o); end
            end
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL stream_empty_valid got=%b exp=0", out_valid_o); end
        checks++; if (out_offs_o[31:0] !== 32'h70) begin failures++; $display("[TB] FAIL stream_hold got=%h exp=70", out_offs_o[31:0]); end
    endtask

    task automatic test_throttle();
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            in_valid_i = uloop_enable_o;
            checks++; if (uloop_enable_o !== ((DEPTH - mq.size()) > LATENCY)) begin failures++; $display("[TB] FAIL throttle_enable c=%0d got=%b exp=%b", c, uloop_enable_o, (DEPTH - mq.size()) > LATENCY); end
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (count_o !== CNT_W'(3)) begin failures++; $display("[TB] FAIL throttle_count got=%0d exp=3", count_o); end
        checks++; if (uloop_enable_o !== 1'b0) begin failures++; $display("[TB] FAIL throttle_enable_held got=%b exp=0", uloop_enable_o); end
    endtask

    task automatic test_overflow();
        drive(1'b1, 1'b0, 1'b0, 32'h400, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h401, 1'b0, 1'b0);
        checks++; if (count_o !== CNT_W'(4)) begin failures++; $display("[TB] FAIL ovf_full_count got=%0d exp=4", count_o); end
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("[TB] FAIL ovf_before got=%b exp=0", overflow_o); end
        step();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            checks++; if (overflow_o !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky c=%0d got=%b exp=1", c, overflow_o); end
            checks++; if (count_o !== CNT_W'(4)) begin failures++; $display("[TB] FAIL ovf_count c=%0d got=%0d exp=4", c, count_o); end
            checks++; if (out_offs_o !== mq[0].offs) begin failures++; $display("[TB] FAIL ovf_head c=%0d got=%h exp=%h", c, out_offs_o[31:0], mq[0].offs[31:0]); end
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        checks++; if (uloop_enable_o !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear_enable got=%b exp=0", uloop_enable_o); end
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("[TB] FAIL ovf_cleared got=%b exp=0", overflow_o); end
        checks++; if (count_o !== '0) begin failures++; $display("[TB] FAIL ovf_clear_count got=%0d exp=0", count_o); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear_done got=%b exp=0", done_o); end
    endtask

    task automatic test_full_push_pop();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h100 + 32'(k), 1'b0, 1'b0);
            step();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h200 + 32'(k), 1'b1, 1'b0);
            checks++; if (count_o !== CNT_W'(4)) begin failures++; $display("[TB] FAIL fpp_count k=%0d got=%0d exp=4", k, count_o); end
            checks++; if (out_offs_o[31:0] !== 32'h100 + 32'(k)) begin failures++; $display("[TB] FAIL fpp_head k=%0d got=%h exp=%h", k, out_offs_o[31:0], 32'h100 + 32'(k)); end
            step();
            checks++; if (overflow_o !== 1'b0) begin failures++; $display("[TB] FAIL fpp_overflow k=%0d got=%b exp=0", k, overflow_o); end
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            checks++; if (out_offs_o[31:0] !== 32'h200 + 32'(k)) begin failures++; $display("[TB] FAIL fpp_drain k=%0d got=%h exp=%h", k, out_offs_o[31:0], 32'h200 + 32'(k)); end
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (count_o !== '0) begin failures++; $display("[TB] FAIL fpp_empty got=%0d exp=0", count_o); end
    endtask

    task automatic test_done_alone();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, k[0], 32'h300 + 32'(k), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            checks++; if (out_offs_o[31:0] !== 32'h300 + 32'(k)) begin failures++; $display("[TB] FAIL done_head k=%0d got=%h exp=%h", k, out_offs_o[31:0], 32'h300 + 32'(k)); end
            checks++; if (out_last_o !== (k == 2)) begin failures++; $display("[TB] FAIL done_last k=%0d got=%b exp=%b", k, out_last_o, k == 2); end
            checks++; if (out_accum_o !== k[0]) begin failures++; $display("[TB] FAIL done_accum k=%0d got=%b exp=%b", k, out_accum_o, k[0]); end
            checks++; if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL done_early k=%0d got=%b exp=0", k, done_o); end
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (done_o !== 1'b1) begin failures++; $display("[TB] FAIL done_pulse got=%b exp=1", done_o); end
        step();
        checks++; if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL done_single got=%b exp=0", done_o); end
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (done_o !== 1'b1) begin failures++; $display("[TB] FAIL done_direct got=%b exp=1", done_o); end
        step();
        checks++; if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL done_direct_end got=%b exp=0", done_o); end
    endtask

    task automatic test_clear_midstream();
        drive(1'b1, 1'b0, 1'b0, 32'h500, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h501, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (count_o !== CNT_W'(2)) begin failures++; $display("[TB] FAIL clr_pre_count got=%0d exp=2", count_o); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (count_o !== '0) begin failures++; $display("[TB] FAIL clr_count got=%0d exp=0", count_o); end
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL clr_valid got=%b exp=0", out_valid_o); end
        for (int c = 0; c < 4; c++) begin
            checks++; if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL clr_done c=%0d got=%b exp=0", c, done_o); end
            step();
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_random();
        entry_t expE;
        logic   v, d, a, rdy, clr;
        for (int c = 0; c < 400; c++) begin
            v   = ($urandom_range(0, 99) < 55);
            d   = ($urandom_range(0, 99) < 12);
            a   = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 99) < 60);
            clr = ($urandom_range(0, 99) < 2);
            drive(v, d, a, $urandom(), rdy, clr);
            expE = (mq.size() > 0) ? mq[0] : mHold;
            checks++; if (out_valid_o !== (mq.size() > 0)) begin failures++; $display("[TB] FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid_o, mq.size() > 0); end
            checks++; if ({out_offs_o, out_idx_o, out_accum_o, out_last_o} !== expE) begin failures++; $display("[TB] FAIL rnd_data c=%0d got offs0=%h last=%b exp offs0=%h last=%b", c, out_offs_o[31:0], out_last_o, expE.offs[31:0], expE.last); end
            checks++; if (count_o !== CNT_W'(mq.size())) begin failures++; $display("[TB] FAIL rnd_count c=%0d got=%0d exp=%0d", c, count_o, mq.size()); end
            checks++; if (overflow_o !== mOverflow) begin failures++; $display("[TB] FAIL rnd_overflow c=%0d got=%b exp=%b", c, overflow_o, mOverflow); end
            checks++; if (done_o !== mDone) begin failures++; $display("[TB] FAIL rnd_done c=%0d got=%b exp=%b", c, done_o, mDone); end
            checks++; if (uloop_enable_o !== (!clr && ((DEPTH - mq.size()) > LATENCY))) begin failures++; $display("[TB] FAIL rnd_enable c=%0d got=%b", c, uloop_enable_o); end
            step();
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        test_reset();
        test_stream();
        test_throttle();
        test_overflow();
        test_full_push_pop();
        test_done_alone();
        test_clear_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
